// File: rtl/kuznechik_l_transform_iter.sv
// Iterative Kuznechik linear transform L = R^R_STEPS: one R-step per clock, valid/ready on both sides.
// Optional inverse direction (L^-1) enabled by defining KUZ_L_INVERSE_EN.
module kuznechik_l_transform_iter #(
  parameter int         R_STEPS = 16,
  parameter logic [7:0] GF_POLY = 8'hC3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
`ifdef KUZ_L_INVERSE_EN
  input  logic         inv,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int            CW        = $clog2(R_STEPS) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(R_STEPS - 1);
  // Multiplier for byte a_i sits at bits [8*i +: 8]; a15 is the most significant byte.
  localparam logic [127:0]  L_COEF    = {8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
                                         8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [127:0]  st_reg, st_next;
  logic [127:0]  out_data_reg, out_data_next;
  logic          out_valid_reg, out_valid_next;
  logic [127:0]  l_arg;
  logic [127:0]  step_data;
  logic [7:0]    prod [16];
  logic [7:0]    l_sum;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] k);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = '0;
    sh  = a;
    for (int b = 0; b < 8; b++) begin
      if (k[b]) acc = acc ^ sh;
      sh = sh[7] ? ({sh[6:0], 1'b0} ^ GF_POLY) : {sh[6:0], 1'b0};
    end
    return acc;
  endfunction

`ifdef KUZ_L_INVERSE_EN
  logic inv_reg, inv_next;
  // The inverse step feeds l() the bytes rotated left by one (a14..a0, a15).
  assign l_arg     = inv_reg ? {st_reg[119:0], st_reg[127:120]} : st_reg;
  assign step_data = inv_reg ? {st_reg[119:0], l_sum} : {l_sum, st_reg[127:8]};
`else
  assign l_arg     = st_reg;
  assign step_data = {l_sum, st_reg[127:8]};
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_mul
      assign prod[gi] = gf_mul(l_arg[8*gi +: 8], L_COEF[8*gi +: 8]);
    end
  endgenerate

  always_comb begin
    l_sum = '0;
    for (int i = 0; i < 16; i++) l_sum = l_sum ^ prod[i];
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    st_next        = st_reg;
    out_data_next  = out_data_reg;
    out_valid_next = out_valid_reg;
`ifdef KUZ_L_INVERSE_EN
    inv_next       = inv_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          st_next    = in_data;
          cnt_next   = '0;
`ifdef KUZ_L_INVERSE_EN
          inv_next   = inv;
`endif
          state_next = RUN;
        end
      end
      RUN: begin
        st_next  = step_data;
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == LAST_STEP) begin
          out_data_next  = step_data;
          out_valid_next = 1'b1;
          state_next     = DONE;
        end
      end
      DONE: begin
        // Returning to IDLE costs a cycle, so no accept can coincide with the hand-off.
        if (out_ready) begin
          out_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      st_reg        <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
`ifdef KUZ_L_INVERSE_EN
      inv_reg       <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      st_reg        <= st_next;
      out_data_reg  <= out_data_next;
      out_valid_reg <= out_valid_next;
`ifdef KUZ_L_INVERSE_EN
      inv_reg       <= inv_next;
`endif
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;

endmodule

// File: tb/tb_kuznechik_l_transform_iter.sv
// Self-checking bench for kuznechik_l_transform_iter: randomized blocks against a byte-array model of L,
// plus a second instance built with R_STEPS=1.
module tb_kuznechik_l_transform_iter;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] in_data, out_data;
  logic         in_valid1, in_ready1, out_valid1, out_ready1, busy1;
  logic [127:0] in_data1, out_data1;
`ifdef KUZ_L_INVERSE_EN
  logic         inv;
  logic         inv1;
`endif

  int checks = 0;
  int errors = 0;

  kuznechik_l_transform_iter #(.R_STEPS(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
`ifdef KUZ_L_INVERSE_EN
    .inv(inv),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  kuznechik_l_transform_iter #(.R_STEPS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
`ifdef KUZ_L_INVERSE_EN
    .inv(inv1),
`endif
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1), .busy(busy1)
  );

  // GF(2^8) product modulo x^8+x^7+x^6+x+1, computed on plain integers.
  function automatic logic [7:0] gmul(input int a, input int b);
    int p = 0;
    int x = a;
    int y = b;
    while (y != 0) begin
      if ((y & 1) != 0) p = p ^ x;
      x = x << 1;
      if ((x & 256) != 0) x = x ^ 451;
      y = y >> 1;
    end
    return 8'(p);
  endfunction

  // Reference: b[i] is byte a_i; apply nsteps forward R steps or inverse R steps.
  function automatic logic [127:0] ref_l(input logic [127:0] x, input int nsteps, input bit inv_mode);
    int         c [16] = '{1, 148, 32, 133, 16, 194, 192, 1, 251, 1, 192, 194, 16, 133, 32, 148};
    logic [7:0] b [16];
    logic [7:0] nb;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) b[i] = x[8*i +: 8];
    for (int s = 0; s < nsteps; s++) begin
      if (!inv_mode) begin
        nb = '0;
        for (int i = 0; i < 16; i++) nb = nb ^ gmul(int'(b[i]), c[i]);
        for (int i = 0; i < 15; i++) b[i] = b[i+1];
        b[15] = nb;
      end else begin
        nb = gmul(int'(b[15]), c[0]);
        for (int i = 1; i < 16; i++) nb = nb ^ gmul(int'(b[i-1]), c[i]);
        for (int i = 15; i > 0; i--) b[i] = b[i-1];
        b[0] = nb;
      end
    end
    for (int i = 0; i < 16; i++) r[8*i +: 8] = b[i];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one block, wait (bounded) for the result, then complete the output handshake.
  task automatic run_block(input logic [127:0] d, output logic [127:0] res, output int lat);
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 64) begin
      tick();
      lat++;
    end
    res       = out_data;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    in_valid1 = 1'b0; out_ready1 = 1'b1; in_data1 = '0;
    tick(); tick();
    rst_n = 1'b1;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100 || out_data !== 128'd0) begin
      errors++;
      $display("FAIL reset_state: in_ready/out_valid/busy=%b out_data=%h want 100 and 0", {in_ready, out_valid, busy}, out_data);
    end
    checks++;
    if ({in_ready1, out_valid1, busy1} !== 3'b100) begin
      errors++;
      $display("FAIL reset_state_r1: got %b want 100", {in_ready1, out_valid1, busy1});
    end
    $display("reset: in_ready=%b out_valid=%b busy=%b", in_ready, out_valid, busy);
  endtask

  task automatic test_zero();
    logic [127:0] res;
    int lat;
    run_block(128'd0, res, lat);
    checks++;
    if (lat !== 16 || res !== 128'd0) begin
      errors++;
      $display("FAIL zero_block: latency=%0d data=%h want 16 and 0", lat, res);
    end
    $display("zero: latency=%0d out=%h", lat, res);
  endtask

  task automatic test_known();
    logic [127:0] res;
    int lat;
    run_block(128'h64a59400000000000000000000000000, res, lat);
    checks++;
    if (lat !== 16 || res !== 128'hd456584dd0e3e84cc3166e4b7fa2890d) begin
      errors++;
      $display("FAIL known_vector: latency=%0d data=%h want 16 and d456584dd0e3e84cc3166e4b7fa2890d", lat, res);
    end
    $display("known: latency=%0d out=%h", lat, res);
  endtask

  task automatic test_random();
    logic [127:0] d, res, exp_v;
    int lat;
    for (int n = 0; n < 6; n++) begin
      d     = rand128();
      exp_v = ref_l(d, 16, 1'b0);
      run_block(d, res, lat);
      checks++;
      if (lat !== 16 || res !== exp_v) begin
        errors++;
        $display("FAIL random_%0d: in=%h latency=%0d got=%h want=%h", n, d, lat, res, exp_v);
      end
      $display("random %0d: in=%h out=%h latency=%0d", n, d, res, lat);
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] d, held, exp_v;
    int wait_cyc = 0;
    d     = rand128();
    exp_v = ref_l(d, 16, 1'b0);
    in_data = d; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL run_flags: busy=%b in_ready=%b want 1 and 0", busy, in_ready);
    end
    while (!out_valid && wait_cyc < 64) begin
      tick();
      wait_cyc++;
    end
    held = out_data;
    checks++;
    if (held !== exp_v) begin
      errors++;
      $display("FAIL bp_result: got=%h want=%h", held, exp_v);
    end
    in_valid = 1'b1;
    in_data  = rand128();
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_v || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d: out_valid=%b in_ready=%b out_data=%h want 1 0 %h", c, out_valid, in_ready, out_data, exp_v);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b want 0 and 1", out_valid, in_ready);
    end
    $display("backpressure: held=%h for 20 cycles", held);
  endtask

  task automatic test_reset_midrun();
    logic [127:0] d, res, exp_v;
    int lat;
    bit seen = 1'b0;
    in_data = rand128(); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 128'd0) begin
      errors++;
      $display("FAIL midrun_reset: in_ready=%b out_valid=%b busy=%b out_data=%h", in_ready, out_valid, busy, out_data);
    end
    for (int c = 0; c < 20; c++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL midrun_discard: out_valid=1 want 0 after reset");
    end
    d     = rand128();
    exp_v = ref_l(d, 16, 1'b0);
    run_block(d, res, lat);
    checks++;
    if (lat !== 16 || res !== exp_v) begin
      errors++;
      $display("FAIL midrun_fresh: latency=%0d got=%h want=%h", lat, res, exp_v);
    end
    $display("midrun reset: fresh in=%h out=%h", d, res);
  endtask

  task automatic test_back_to_back();
    logic [127:0] exp_q [$];
    int           acc_cyc [$];
    logic [127:0] exp_v;
    int  accepts = 0;
    int  outs = 0;
    int  cyc = 0;
    bit  acc_now;
    out_ready = 1'b1;
    in_data   = rand128();
    in_valid  = 1'b1;
    while (outs < 3 && cyc < 200) begin
      acc_now = 1'b0;
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_l(in_data, 16, 1'b0));
        acc_cyc.push_back(cyc);
        accepts++;
        acc_now = 1'b1;
      end
      if (out_valid) begin
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 128'd0;
        checks++;
        if (out_data !== exp_v) begin
          errors++;
          $display("FAIL b2b_data_%0d: got=%h want=%h", outs, out_data, exp_v);
        end
        $display("b2b out %0d: %h at cycle %0d", outs, out_data, cyc);
        outs++;
      end
      tick();
      cyc++;
      if (acc_now) begin
        in_data = rand128();
        if (accepts == 3) in_valid = 1'b0;
      end
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checks++;
    if (outs !== 3 || acc_cyc.size() !== 3) begin
      errors++;
      $display("FAIL b2b_count: outputs=%0d accepts=%0d want 3 and 3", outs, acc_cyc.size());
    end else begin
      checks++;
      if (acc_cyc[1] - acc_cyc[0] !== 18 || acc_cyc[2] - acc_cyc[1] !== 18) begin
        errors++;
        $display("FAIL b2b_interval: got %0d and %0d want 18", acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
      end
    end
  endtask

  task automatic test_rsteps1();
    logic [127:0] d, exp_v;
    for (int n = 0; n < 3; n++) begin
      d = (n == 0) ? 128'h100 : rand128();
      exp_v = (n == 0) ? 128'h94000000000000000000000000000001 : ref_l(d, 1, 1'b0);
      in_data1 = d; in_valid1 = 1'b1;
      tick();
      in_valid1 = 1'b0;
      checks++;
      if (out_valid1 !== 1'b0) begin
        errors++;
        $display("FAIL r1_early_%0d: out_valid=%b want 0", n, out_valid1);
      end
      tick();
      checks++;
      if (out_valid1 !== 1'b1 || out_data1 !== exp_v) begin
        errors++;
        $display("FAIL r1_result_%0d: out_valid=%b got=%h want=%h", n, out_valid1, out_data1, exp_v);
      end
      $display("r_steps=1 %0d: in=%h out=%h", n, d, out_data1);
      tick();
    end
  endtask

`ifdef KUZ_L_INVERSE_EN
  task automatic test_inverse();
    logic [127:0] d, y, res;
    int lat;
    inv = 1'b1;
    run_block(128'hd456584dd0e3e84cc3166e4b7fa2890d, res, lat);
    checks++;
    if (lat !== 16 || res !== 128'h64a59400000000000000000000000000) begin
      errors++;
      $display("FAIL inverse_known: latency=%0d got=%h want 64a59400000000000000000000000000", lat, res);
    end
    $display("inverse known: out=%h", res);
    for (int n = 0; n < 3; n++) begin
      d = rand128();
      inv = 1'b0;
      run_block(d, y, lat);
      inv = 1'b1;
      run_block(y, res, lat);
      checks++;
      if (res !== d || res !== ref_l(y, 16, 1'b1)) begin
        errors++;
        $display("FAIL inverse_roundtrip_%0d: got=%h want=%h", n, res, d);
      end
      $display("inverse roundtrip %0d: in=%h back=%h", n, d, res);
    end
    inv = 1'b0;
  endtask
`endif

  initial begin
`ifdef KUZ_L_INVERSE_EN
    inv = 1'b0;
    inv1 = 1'b0;
`endif
    test_reset();
    test_zero();
    test_known();
    test_random();
    test_backpressure();
    test_reset_midrun();
    test_back_to_back();
    test_rsteps1();
`ifdef KUZ_L_INVERSE_EN
    test_inverse();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
